fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of address, PC and instruction.
REQ-002 SHALL have parameter PC_INC, default 1, address increment per instruction (word addressing).
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL have parameter DEPTH, default 4, prefetch entries; power of two, >= 2.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-007 SHALL have port redirect_i  in  1  taken branch/jump from execute (pcsrcE).
REQ-008 SHALL have port redirect_pc_i  in  XLEN  redirect target (pctargetE).
REQ-009 SHALL have port imem_req_o  out  1  fetch request valid.
REQ-010 SHALL have port imem_addr_o  out  XLEN  fetch address.
REQ-011 SHALL have port imem_rvalid_i  in  1  response valid; in order, latency >= 1 cycle.
REQ-012 SHALL have port imem_rdata_i  in  XLEN  response instruction.
REQ-013 SHALL have port dec_valid_o  out  1  head entry valid to decode.
REQ-014 SHALL have port dec_ready_i  in  1  decode accepts; low = stall.
REQ-015 SHALL have port dec_instr_o, dec_pc_o, dec_pcinc_o  out  XLEN each  instrD, pcD, pcincr4D of head entry.

Function
REQ-016 SHALL hold fetch PC register pc_q; imem_addr_o = pc_q.
REQ-017 SHALL assert imem_req_o when (allocated entries) < DEPTH and redirect_i = 0; each such cycle is an issue.
REQ-018 SHALL, on issue, allocate tail entry with pc = pc_q, pcinc = pc_q + PC_INC (mod 2^XLEN), filled = 0, and set pc_q <= pc_q + PC_INC.
REQ-019 SHALL write imem_rdata_i into the oldest unfilled entry on imem_rvalid_i and set its filled bit, unless discard count > 0 (REQ-023).
REQ-020 SHALL drive dec_valid_o = head allocated AND filled; dec_* outputs are the head entry fields, zero when not valid.
REQ-021 SHALL pop the head when dec_valid_o AND dec_ready_i; holds outputs stable while dec_ready_i = 0.
REQ-022 SHALL allow issue, response and pop in the same cycle; pop frees a slot usable by issue only on the next cycle.
REQ-023 SHALL, on redirect_i: pc_q <= redirect_pc_i; invalidate all entries (empty, pointers reset); discard count <= outstanding unfilled requests (including any response arriving that same cycle being ignored, i.e. count minus that response); no issue and no pop that cycle.
REQ-024 SHALL drop each imem_rvalid_i response while discard count > 0 and decrement it; discard count never underflows.
REQ-025 SHALL treat redirect during an active discard by adding the new cycle's outstanding count to the remaining discard count.
REQ-026 SHALL issue from redirect_pc_i on the cycle after redirect_i if not full.
REQ-027 SHALL wrap entry pointers modulo DEPTH; full = DEPTH allocated, empty = 0 allocated.
REQ-028 SHALL ignore imem_rvalid_i with no outstanding request (assertion in simulation).

Reset
REQ-029 SHALL, while rst = 1, force pc_q = RESET_PC, all entries invalid, discard count 0, imem_req_o = 0, dec_valid_o = 0, dec_* = 0.
REQ-030 SHALL issue first request to RESET_PC the first cycle after rst deasserts; reset mid-operation abandons outstanding requests (memory assumed reset alongside).

Structure
REQ-031 SHALL place XLEN default, PC_INC default and entry struct {instr, pc, pcinc, filled} in shared package fetch_pkg.
REQ-032 SHALL implement the entry storage/pointers as sub-module fetch_buffer (alloc, fill, pop, flush ports).

Verification
REQ-033 Reset release, 1-cycle memory, dec_ready_i = 1 -> addresses 0,1,2,...; decode sees pc 0,1,2 with pcinc 1,2,3, one per cycle after pipeline fill.
REQ-034 dec_ready_i = 0 for 10 cycles -> exactly DEPTH=4 requests issued, outputs frozen at pc 0, then resume in order without loss.
REQ-035 Redirect to 0x100 with 3 outstanding, 3-cycle latency -> next 3 responses dropped, first decoded pc = 0x100, pcinc = 0x101.
REQ-036 Redirect coincident with response and with dec_ready_i = 1 -> no pop, response dropped, discard count correct.
REQ-037 pc_q = 0xFFFFFFFF, PC_INC=1 -> pcinc = 0x00000000, next address 0x00000000.
REQ-038 rst asserted mid-stream with 2 entries filled -> dec_valid_o = 0 immediately, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction fetch unit: default widths and the
//   prefetch buffer entry layout used by fetch_unit and fetch_buffer.
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT   = 32;
  localparam int unsigned PC_INC_DEFAULT = 1;

  // Width of the counter of responses still owed by memory for requests whose
  // entries were flushed. Several back-to-back redirects can stack up here.
  localparam int unsigned DISCARD_W = 8;

  typedef logic [XLEN_DEFAULT-1:0] xlen_t;

  // One prefetch slot: the instruction word, its PC and the sequential next PC
  // (pcincr4D in the decode stage), plus whether the response has arrived.
  typedef struct packed {
    xlen_t instr;
    xlen_t pc;
    xlen_t pcinc;
    logic  filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//   In-order prefetch queue of DEPTH entries. Entries are allocated at the
//   tail when a request issues, filled in allocation order as responses
//   return, and popped from the head once filled.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   alloc_i          allocate tail entry with alloc_pc_i / alloc_pcinc_i
//   fill_i           write fill_data_i into the oldest unfilled entry
//   pop_i            retire the head entry (must be filled)
//   flush_i          drop every entry and reset the pointers (wins over all)
//   head_o           head entry; all-zero when the head is not filled, so
//                    head_o.filled doubles as the decode valid
//   count_o          allocated entries
//   unfilled_o       allocated entries still waiting for a response
// -----------------------------------------------------------------------------
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_i,
  input  xlen_t                    alloc_pc_i,
  input  xlen_t                    alloc_pcinc_i,
  input  logic                     fill_i,
  input  xlen_t                    fill_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   unfilled_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  ptr_t rd_ptr_q,   rd_ptr_d;
  ptr_t fill_ptr_q, fill_ptr_d;
  ptr_t wr_ptr_q,   wr_ptr_d;
  cnt_t count_q,    count_d;
  cnt_t filled_q,   filled_d;

  fetch_entry_t mem_q [DEPTH];

  // Pointers are AW bits wide and DEPTH is a power of two, so the +1 wraps
  // modulo DEPTH for free.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    rd_ptr_d   = rd_ptr_q;
    fill_ptr_d = fill_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    filled_d   = filled_q;
    if (flush_i) begin
      rd_ptr_d   = '0;
      fill_ptr_d = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      filled_d   = '0;
    end else begin
      if (alloc_i) wr_ptr_d   = wr_ptr_q   + ptr_t'(1);
      if (fill_i)  fill_ptr_d = fill_ptr_q + ptr_t'(1);
      if (pop_i)   rd_ptr_d   = rd_ptr_q   + ptr_t'(1);
      count_d  = count_q  + cnt_t'(alloc_i) - cnt_t'(pop_i);
      filled_d = filled_q + cnt_t'(fill_i)  - cnt_t'(pop_i);
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      fill_ptr_q <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      filled_q   <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      fill_ptr_q <= fill_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      filled_q   <= filled_d;
    end
  end

  // NOTE: the entry storage is deliberately not reset; an entry is only ever
  // observed while count_q says it is allocated, and allocation rewrites it.
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      if (alloc_i) begin
        mem_q[wr_ptr_q] <= '{instr: '0, pc: alloc_pc_i, pcinc: alloc_pcinc_i, filled: 1'b0};
      end
      // The fill slot is always allocated and the tail slot never is, so these
      // two writes can not land on the same entry.
      if (fill_i) begin
        mem_q[fill_ptr_q].instr  <= fill_data_i;
        mem_q[fill_ptr_q].filled <= 1'b1;
      end
    end
  end

  always_comb begin
    head_o = '0;
    if (count_q != '0 && mem_q[rd_ptr_q].filled) head_o = mem_q[rd_ptr_q];
  end

  assign count_o    = count_q;
  assign unfilled_o = count_q - filled_q;

  always @(posedge clk) begin
    if (!rst && !flush_i) begin
      assert (!(alloc_i && count_q == cnt_t'(DEPTH)))
        else $error("fetch_buffer: allocate while full");
      assert (!(fill_i && count_q == filled_q))
        else $error("fetch_buffer: fill with no unfilled entry");
      assert (!(pop_i && !head_o.filled))
        else $error("fetch_buffer: pop of an unfilled head");
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch front end with a DEPTH-entry prefetch buffer. Issues one
//   sequential request per cycle while a slot is free, accepts in-order memory
//   responses, hands filled entries to decode, and on a taken branch restarts
//   at the target while discarding responses to the abandoned requests.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   redirect_i, redirect_pc_i   taken branch/jump from execute and its target
//   imem_req_o, imem_addr_o     fetch request and address (= pc_q)
//   imem_rvalid_i, imem_rdata_i in-order response, latency of one cycle or more
//   dec_valid_o, dec_ready_i    head entry handshake with decode
//   dec_instr_o, dec_pc_o,      head entry fields, zero while dec_valid_o = 0
//   dec_pcinc_o
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter int unsigned     PC_INC   = PC_INC_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [XLEN-1:0] dec_instr_o,
  output logic [XLEN-1:0] dec_pc_o,
  output logic [XLEN-1:0] dec_pcinc_o
);

  localparam int unsigned     AW      = $clog2(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(PC_INC);

  // The entry layout lives in the shared package at its default width.
  if (XLEN != XLEN_DEFAULT) begin : g_xlen_check
    $error("fetch_unit: XLEN must match fetch_pkg::XLEN_DEFAULT");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("fetch_unit: DEPTH must be a power of two and at least 2");
  end

  logic [XLEN-1:0]      pc_q, pc_d;
  logic [DISCARD_W-1:0] discard_q, discard_d;

  logic [AW:0]  count;
  logic [AW:0]  unfilled;
  fetch_entry_t head;

  logic full;
  logic issue;
  logic rsp_drop;
  logic rsp_fill;
  logic rsp_taken;
  logic pop;

  always_comb begin
    full = (count == (AW+1)'(DEPTH));

    // Count is registered, so a pop this cycle frees its slot only next cycle.
    issue = !rst && !full && !redirect_i;

    // Responses belong first to flushed requests (discard_q of them), then to
    // the oldest unfilled entry. rsp_taken is any response we can account for.
    rsp_drop  = imem_rvalid_i && (discard_q != '0);
    rsp_taken = imem_rvalid_i && ((discard_q != '0) || (unfilled != '0));
    rsp_fill  = imem_rvalid_i && (discard_q == '0) && (unfilled != '0) && !redirect_i;

    pop = head.filled && dec_ready_i && !redirect_i;

    pc_d = pc_q;
    if (redirect_i)  pc_d = redirect_pc_i;
    else if (issue)  pc_d = pc_q + PC_STEP;

    // On redirect every request still owed by memory becomes a discard: those
    // already being discarded plus the flushed unfilled entries, less the one
    // response consumed this very cycle.
    discard_d = discard_q;
    if (redirect_i) begin
      discard_d = discard_q + DISCARD_W'(unfilled) - DISCARD_W'(rsp_taken);
    end else if (rsp_drop) begin
      discard_d = discard_q - DISCARD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      discard_q <= '0;
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk           (clk),
    .rst           (rst),
    .alloc_i       (issue),
    .alloc_pc_i    (pc_q),
    .alloc_pcinc_i (pc_q + PC_STEP),
    .fill_i        (rsp_fill),
    .fill_data_i   (imem_rdata_i),
    .pop_i         (pop),
    .flush_i       (redirect_i),
    .head_o        (head),
    .count_o       (count),
    .unfilled_o    (unfilled)
  );

  assign imem_req_o  = issue;
  assign imem_addr_o = pc_q;

  // The buffer zeroes the head while it is not filled, and its count is reset
  // asynchronously, so these drop to zero as soon as rst rises.
  assign dec_valid_o = head.filled;
  assign dec_instr_o = head.instr;
  assign dec_pc_o    = head.pc;
  assign dec_pcinc_o = head.pcinc;

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rvalid_i && !rsp_taken))
        else $error("fetch_unit: response with no outstanding request");
      assert (!(redirect_i && discard_d < discard_q && unfilled != '0))
        else $error("fetch_unit: discard counter overflow");
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit with an in-order instruction memory model of
//   programmable latency. Instruction words are addr ^ 32'h5A5A_0000 so the
//   word seen at decode identifies which request it answered.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        dec_valid_o;
  logic        dec_ready_i = 1'b0;
  logic [31:0] dec_instr_o;
  logic [31:0] dec_pc_o;
  logic [31:0] dec_pcinc_o;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN     (32),
    .PC_INC   (1),
    .RESET_PC (32'h0),
    .DEPTH    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .dec_instr_o   (dec_instr_o),
    .dec_pc_o      (dec_pc_o),
    .dec_pcinc_o   (dec_pcinc_o)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t mq[$];
  int   cyc     = 0;
  int   lat     = 1;
  int   n_issue = 0;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge: present this cycle's memory response,
  // then let the combinational outputs settle.
  task automatic begin_cycle();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (mq.size() > 0) begin
      if (mq[0].due <= cyc) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = instr_of(mq[0].addr);
        void'(mq.pop_front());
      end
    end
    #1;
  endtask

  // Record this cycle's request (response due lat cycles later) and advance.
  task automatic end_cycle();
    req_t r;
    if (imem_req_o) begin
      r.addr = imem_addr_o;
      r.due  = cyc + lat;
      mq.push_back(r);
      n_issue++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      begin_cycle();
      end_cycle();
    end
  endtask

  // The memory is reset together with the fetch unit.
  task automatic do_reset();
    rst           = 1'b1;
    redirect_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    mq.delete();
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  initial begin
    // ---- reset state ----
    @(negedge clk);
    #1;
    check("rst_req",   imem_req_o,  0);
    check("rst_valid", dec_valid_o, 0);
    check("rst_pc",    dec_pc_o,    0);
    check("rst_instr", dec_instr_o, 0);
    check("rst_addr",  imem_addr_o, 0);
    do_reset();

    // ---- 1-cycle memory, decode always ready: sequential stream ----
    lat = 1;
    dec_ready_i = 1'b1;
    begin_cycle();
    check("seq_req0",  imem_req_o,  1);
    check("seq_addr0", imem_addr_o, 0);
    end_cycle();
    begin_cycle();
    check("seq_addr1",  imem_addr_o, 1);
    check("seq_nvalid", dec_valid_o, 0);
    end_cycle();
    for (int i = 0; i < 3; i++) begin
      begin_cycle();
      check("seq_valid", dec_valid_o, 1);
      check("seq_pc",    dec_pc_o,    i);
      check("seq_pcinc", dec_pcinc_o, i + 1);
      check("seq_instr", dec_instr_o, instr_of(i));
      end_cycle();
    end

    // ---- reset mid-stream with two entries filled ----
    do_reset();
    dec_ready_i = 1'b0;
    idle_cycles(3);
    begin_cycle();
    check("mrst_pre_valid", dec_valid_o, 1);
    check("mrst_pre_pc",    dec_pc_o,    0);
    rst = 1'b1;
    #1;
    check("mrst_valid", dec_valid_o, 0);
    check("mrst_pc",    dec_pc_o,    0);
    check("mrst_instr", dec_instr_o, 0);
    check("mrst_req",   imem_req_o,  0);
    check("mrst_addr",  imem_addr_o, 0);
    do_reset();

    // ---- decode stalled for 10 cycles: buffer fills, outputs freeze ----
    n0 = n_issue;
    for (int i = 0; i < 10; i++) begin
      begin_cycle();
      if (i == 0) begin
        check("stall_first_req",  imem_req_o,  1);
        check("stall_first_addr", imem_addr_o, 0);
      end
      if (i >= 2) begin
        check("stall_valid", dec_valid_o, 1);
        check("stall_pc",    dec_pc_o,    0);
      end
      end_cycle();
    end
    check("stall_issued", n_issue - n0, 4);
    dec_ready_i = 1'b1;
    begin_cycle();
    check("resume_full_noreq", imem_req_o, 0);
    check("resume_pc0",        dec_pc_o,   0);
    end_cycle();
    for (int i = 1; i < 5; i++) begin
      begin_cycle();
      if (i == 1) begin
        check("resume_req",  imem_req_o,  1);
        check("resume_addr", imem_addr_o, 4);
      end
      check("resume_valid", dec_valid_o, 1);
      check("resume_pc",    dec_pc_o,    i);
      check("resume_instr", dec_instr_o, instr_of(i));
      end_cycle();
    end

    // ---- redirect coincident with a response while head is valid ----
    do_reset();
    lat = 2;
    dec_ready_i = 1'b1;
    idle_cycles(3);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    begin_cycle();
    check("coin_req",   imem_req_o,  0);
    check("coin_valid", dec_valid_o, 1);
    check("coin_pc",    dec_pc_o,    0);
    end_cycle();
    redirect_i = 1'b0;
    begin_cycle();
    check("coin_tgt_req",  imem_req_o,  1);
    check("coin_tgt_addr", imem_addr_o, 32'h40);
    check("coin_flushed",  dec_valid_o, 0);
    end_cycle();
    for (int i = 0; i < 2; i++) begin
      begin_cycle();
      check("coin_wait", dec_valid_o, 0);
      end_cycle();
    end
    begin_cycle();
    check("coin_dec_valid", dec_valid_o, 1);
    check("coin_dec_pc",    dec_pc_o,    32'h40);
    check("coin_dec_pcinc", dec_pcinc_o, 32'h41);
    check("coin_dec_instr", dec_instr_o, instr_of(32'h40));
    end_cycle();
    begin_cycle();
    check("coin_dec_pc2", dec_pc_o, 32'h41);
    end_cycle();

    // ---- redirect to 0x100 with three requests in flight, latency 3 ----
    do_reset();
    lat = 3;
    dec_ready_i = 1'b1;
    idle_cycles(3);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    begin_cycle();
    check("rd_req",   imem_req_o,  0);
    check("rd_valid", dec_valid_o, 0);
    end_cycle();
    redirect_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      begin_cycle();
      if (i == 0) check("rd_tgt_addr", imem_addr_o, 32'h100);
      check("rd_dropped", dec_valid_o, 0);
      end_cycle();
    end
    begin_cycle();
    check("rd_dec_valid", dec_valid_o, 1);
    check("rd_dec_pc",    dec_pc_o,    32'h100);
    check("rd_dec_pcinc", dec_pcinc_o, 32'h101);
    check("rd_dec_instr", dec_instr_o, instr_of(32'h100));
    end_cycle();
    begin_cycle();
    check("rd_dec_pc2", dec_pc_o, 32'h101);
    end_cycle();

    // ---- PC wrap at the top of the address space ----
    do_reset();
    lat = 1;
    dec_ready_i   = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFF;
    begin_cycle();
    check("wrap_redir_req", imem_req_o, 0);
    end_cycle();
    redirect_i = 1'b0;
    begin_cycle();
    check("wrap_req",  imem_req_o,  1);
    check("wrap_addr", imem_addr_o, 32'hFFFF_FFFF);
    end_cycle();
    begin_cycle();
    check("wrap_next_addr", imem_addr_o, 32'h0);
    end_cycle();
    begin_cycle();
    check("wrap_dec_pc",    dec_pc_o,    32'hFFFF_FFFF);
    check("wrap_dec_pcinc", dec_pcinc_o, 32'h0);
    check("wrap_dec_instr", dec_instr_o, instr_of(32'hFFFF_FFFF));
    end_cycle();
    begin_cycle();
    check("wrap_dec_pc2",    dec_pc_o,    32'h0);
    check("wrap_dec_pcinc2", dec_pcinc_o, 32'h1);
    end_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
